node_request_queue: RTL and testbench



---
 rtl/interposer_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/node_request_queue.sv | 165 ++++++++++++++++
 tb/tb_node_request_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interposer_pkg.sv
// rtl/interposer_pkg.sv - shared interposer bus constants and node queue state type
package interposer_pkg;

   localparam int NODE_COUNT = 8;
   localparam int DEST_WIDTH = $clog2(NODE_COUNT);

   // Request slice layout is {on, dest}; the on bit sits just above dest.
   localparam int REQ_ON_BIT = DEST_WIDTH;

   // Control slice order from the arbiter is {tx, rx, bp}.
   localparam int CTRL_TX_BIT = 2;
   localparam int CTRL_RX_BIT = 1;
   localparam int CTRL_BP_BIT = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REQ,
      ST_SEND,
      ST_HOLD
   } node_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular synchronous FIFO with head-of-queue read
module sync_fifo
   import interposer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses pushes even when a pop lands in the same cycle.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/node_request_queue.sv
// rtl/node_request_queue.sv - per-node transmit queue, arbiter request and bus tx/rx front end
module node_request_queue
   import interposer_pkg::*;
#(
   parameter int NODE_ID    = 0,
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEST_WIDTH = interposer_pkg::DEST_WIDTH,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  logic [DEST_WIDTH-1:0]  enq_dest,
   input  logic [DATA_WIDTH-1:0]  enq_data,
   output logic [DEST_WIDTH:0]    request,
   input  logic                   ctrl_tx,
   input  logic                   ctrl_rx,
   input  logic                   ctrl_bp,
   input  logic [DATA_WIDTH-1:0]  bus_in,
   output logic [DATA_WIDTH-1:0]  tx_data,
   output logic                   tx_valid,
   output logic [DATA_WIDTH-1:0]  rx_data,
   output logic                   rx_valid,
   output logic                   drop_err,
   output logic                   spurious_err,
   output logic [CNT_WIDTH-1:0]   max_wait
);

   localparam int FW = DEST_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [DEST_WIDTH-1:0] SELF_DEST = DEST_WIDTH'(NODE_ID);

   node_state_e             state;
   node_state_e             next_state;
   logic [FW-1:0]           head;
   logic [DEST_WIDTH-1:0]   head_dest;
   logic [DATA_WIDTH-1:0]   head_data;
   logic [CW-1:0]           fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push;
   logic                    pop;
   logic                    grant;
   logic [CNT_WIDTH-1:0]    wait_cnt;
   logic [1:0]              unused_bits;

   // Bypass is handled outside this block; the empty flag is redundant with count.
   assign unused_bits = {ctrl_bp, fifo_empty};

   assign enq_ready = ~fifo_full;
   assign push      = enq_valid & enq_ready;
   assign head_dest = head[FW-1:DATA_WIDTH];
   assign head_data = head[DATA_WIDTH-1:0];
   assign grant     = (state == ST_REQ) & ctrl_tx;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({enq_dest, enq_data}),
      .pop   (pop),
      .head  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, FIFO pop and the request slice; request is only live in REQ.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      request    = '0;
      unique case (state)
         ST_IDLE: begin
            if (fifo_count != '0) begin
               next_state = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (head_dest == SELF_DEST) begin
               pop        = 1'b1;
               next_state = ST_IDLE;
            end else begin
               next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            request = {1'b1, head_dest};
            if (ctrl_tx) begin
               next_state = ST_SEND;
            end
         end
         ST_SEND: begin
            pop        = 1'b1;
            next_state = ST_HOLD;
         end
         ST_HOLD: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Registered tx word and event pulses; tx is valid exactly during SEND.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_valid     <= 1'b0;
         tx_data      <= '0;
         drop_err     <= 1'b0;
         spurious_err <= 1'b0;
      end else begin
         tx_valid     <= grant;
         tx_data      <= grant ? head_data : '0;
         drop_err     <= (state == ST_CHECK) && (head_dest == SELF_DEST);
         spurious_err <= ctrl_tx && (state != ST_REQ);
      end
   end

   // Receive capture runs independently of the transmit FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= ctrl_rx;
         if (ctrl_rx) begin
            rx_data <= bus_in;
         end
      end
   end

   // Grant-wait statistic: counts REQ cycles before the grant, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         max_wait <= '0;
      end else begin
         if (state == ST_CHECK) begin
            wait_cnt <= '0;
         end else if ((state == ST_REQ) && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (grant && (wait_cnt > max_wait)) begin
            max_wait <= wait_cnt;
         end
      end
   end

endmodule

// File: tb/tb_node_request_queue.sv
// tb/tb_node_request_queue.sv - randomized self-checking bench for node_request_queue
module tb_node_request_queue;

   localparam int NODE_ID = 3;
   localparam int DEPTH   = 4;
   localparam int DW      = 32;
   localparam int DSW     = 3;
   localparam int CNTW    = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            enq_valid;
   logic            enq_ready;
   logic [DSW-1:0]  enq_dest;
   logic [DW-1:0]   enq_data;
   logic [DSW:0]    request;
   logic            ctrl_tx;
   logic            ctrl_rx;
   logic            ctrl_bp;
   logic [DW-1:0]   bus_in;
   logic [DW-1:0]   tx_data;
   logic            tx_valid;
   logic [DW-1:0]   rx_data;
   logic            rx_valid;
   logic            drop_err;
   logic            spurious_err;
   logic [CNTW-1:0] max_wait;

   int total = 0;
   int bad   = 0;
   int drop_seen = 0;
   int drop_used = 0;
   logic [DW-1:0] exp_rx = '0;
   logic [DSW+DW-1:0] model_q [$];

   always #5 clk = ~clk;

   node_request_queue #(
      .NODE_ID    (NODE_ID),
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DW),
      .DEST_WIDTH (DSW),
      .CNT_WIDTH  (CNTW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enq_valid    (enq_valid),
      .enq_ready    (enq_ready),
      .enq_dest     (enq_dest),
      .enq_data     (enq_data),
      .request      (request),
      .ctrl_tx      (ctrl_tx),
      .ctrl_rx      (ctrl_rx),
      .ctrl_bp      (ctrl_bp),
      .bus_in       (bus_in),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .drop_err     (drop_err),
      .spurious_err (spurious_err),
      .max_wait     (max_wait)
   );

   // Count discard pulses and reject any request addressed to this node.
   always @(negedge clk) begin
      if (!reset) begin
         if (drop_err) drop_seen++;
         if (request[DSW]) begin
            total++;
            if (request[DSW-1:0] == NODE_ID) begin
               bad++;
               $display("FAIL self_request got=%b", request);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pkt(input logic [DSW-1:0] d, input logic [DW-1:0] data);
      enq_valid = 1'b1;
      enq_dest  = d;
      enq_data  = data;
      if (enq_ready) model_q.push_back({d, data});
      step();
      enq_valid = 1'b0;
   endtask

   function automatic logic [DSW-1:0] other_dest();
      logic [DSW-1:0] d;
      do d = DSW'($urandom_range(0, 7)); while (d == NODE_ID);
      return d;
   endfunction

   // Serve one queued packet: expect a discard for self-address, else a request, grant and send.
   task automatic drain_one(input logic [DSW+DW-1:0] pkt, input int delay);
      logic [DSW-1:0] d;
      logic [DW-1:0]  data;
      int n;
      d    = pkt[DSW+DW-1:DW];
      data = pkt[DW-1:0];
      if (d == NODE_ID) begin
         n = 0;
         while (drop_seen == drop_used && n < 20) begin step(); n++; end
         total++;
         if (drop_seen == drop_used) begin
            bad++;
            $display("FAIL drop_timeout got=none exp=drop_err pulse");
         end else begin
            drop_used++;
         end
      end else begin
         n = 0;
         while (!request[DSW] && n < 20) begin step(); n++; end
         total++;
         if (request !== {1'b1, d}) begin
            bad++;
            $display("FAIL request got=%b exp=%b", request, {1'b1, d});
         end
         for (int i = 0; i < delay; i++) begin
            step();
            total++;
            if (request !== {1'b1, d}) begin
               bad++;
               $display("FAIL request_hold got=%b exp=%b", request, {1'b1, d});
            end
         end
         ctrl_tx = 1'b1;
         step();
         ctrl_tx = 1'b0;
         total++;
         if (tx_valid !== 1'b1 || tx_data !== data) begin
            bad++;
            $display("FAIL tx got=%b/%h exp=1/%h", tx_valid, tx_data, data);
         end
         total++;
         if (request !== '0) begin
            bad++;
            $display("FAIL send_request got=%b exp=0", request);
         end
         step();
         total++;
         if (tx_valid !== 1'b0 || tx_data !== '0 || request !== '0) begin
            bad++;
            $display("FAIL hold got=%b/%h/%b exp=0/0/0", tx_valid, tx_data, request);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      total++;
      if (request !== '0 || enq_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== '0 ||
          rx_valid !== 1'b0 || rx_data !== '0 || drop_err !== 1'b0 ||
          spurious_err !== 1'b0 || max_wait !== '0) begin
         bad++;
         $display("FAIL %s got=req%b rdy%b txv%b txd%h rxv%b rxd%h drop%b spur%b mw%0d exp=reset values",
                  tag, request, enq_ready, tx_valid, tx_data, rx_valid, rx_data, drop_err,
                  spurious_err, max_wait);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enq_valid = 1'b0; enq_dest = '0; enq_data = '0;
      ctrl_tx = 1'b0; ctrl_rx = 1'b0; ctrl_bp = 1'b0; bus_in = '0;
      step(); step();
      reset = 1'b0;
      check_reset_values("reset_state");
      exp_rx = '0;
   endtask

   task automatic test_single();
      push_pkt(3'd5, 32'hA5A5_0001);
      total++;
      if (request !== '0) begin bad++; $display("FAIL single_idle got=%b exp=0", request); end
      step();
      total++;
      if (request !== '0) begin bad++; $display("FAIL single_check got=%b exp=0", request); end
      step();
      total++;
      if (request !== 4'b1101) begin bad++; $display("FAIL single_req got=%b exp=1101", request); end
      void'(model_q.pop_front());
      step(); step(); step();
      ctrl_tx = 1'b1;
      step();
      ctrl_tx = 1'b0;
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 32'hA5A5_0001) begin
         bad++; $display("FAIL single_tx got=%b/%h exp=1/a5a50001", tx_valid, tx_data);
      end
      step();
      total++;
      if (tx_valid !== 1'b0 || request !== '0) begin
         bad++; $display("FAIL single_hold got=%b/%b exp=0/0", tx_valid, request);
      end
      step();
      total++;
      if (request !== '0) begin bad++; $display("FAIL single_gap got=%b exp=0", request); end
      total++;
      if (max_wait !== 8'd3) begin bad++; $display("FAIL single_max_wait got=%0d exp=3", max_wait); end
   endtask

   task automatic test_full();
      logic [DSW-1:0] d;
      logic [DW-1:0]  data;
      for (int i = 0; i < 5; i++) begin
         d = other_dest();
         data = $urandom;
         enq_valid = 1'b1; enq_dest = d; enq_data = data;
         total++;
         if (enq_ready !== (i < DEPTH)) begin
            bad++; $display("FAIL full_ready push%0d got=%b exp=%b", i, enq_ready, (i < DEPTH));
         end
         if (i < DEPTH) model_q.push_back({d, data});
         step();
      end
      enq_valid = 1'b0;
      total++;
      if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_after got=%b exp=0", enq_ready); end
      while (model_q.size() > 0) drain_one(model_q.pop_front(), $urandom_range(0, 4));
      total++;
      if (enq_ready !== 1'b1) begin bad++; $display("FAIL full_empty_ready got=%b exp=1", enq_ready); end
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if (request !== '0) begin bad++; $display("FAIL full_drained got=%b exp=0", request); end
      end
   endtask

   task automatic test_self_addr();
      int drops_before;
      drops_before = drop_seen;
      push_pkt(3'd3, 32'h0000_0333);
      push_pkt(3'd0, 32'hC0DE_0000);
      while (model_q.size() > 0) drain_one(model_q.pop_front(), $urandom_range(0, 2));
      total++;
      if (drop_seen - drops_before !== 1) begin
         bad++; $display("FAIL self_drop_count got=%0d exp=1", drop_seen - drops_before);
      end
   endtask

   task automatic test_spurious();
      int n;
      step();
      ctrl_tx = 1'b1;
      step();
      ctrl_tx = 1'b0;
      total++;
      if (spurious_err !== 1'b1 || tx_valid !== 1'b0) begin
         bad++; $display("FAIL spurious got=%b/%b exp=1/0", spurious_err, tx_valid);
      end
      step();
      total++;
      if (spurious_err !== 1'b0) begin bad++; $display("FAIL spurious_pulse got=%b exp=0", spurious_err); end
      push_pkt(3'd5, 32'h5555_AAAA);
      void'(model_q.pop_front());
      n = 0;
      while (!request[DSW] && n < 20) begin step(); n++; end
      total++;
      if (request !== 4'b1101) begin bad++; $display("FAIL sim_req got=%b exp=1101", request); end
      ctrl_tx = 1'b1; ctrl_rx = 1'b1; bus_in = 32'h0000_1234;
      step();
      ctrl_tx = 1'b0; ctrl_rx = 1'b0;
      exp_rx = 32'h0000_1234;
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h5555_AAAA || rx_valid !== 1'b1 ||
          rx_data !== exp_rx || spurious_err !== 1'b0) begin
         bad++;
         $display("FAIL simultaneous got=txv%b txd%h rxv%b rxd%h spur%b exp=1/5555aaaa/1/1234/0",
                  tx_valid, tx_data, rx_valid, rx_data, spurious_err);
      end
      step();
      total++;
      if (rx_valid !== 1'b0 || rx_data !== exp_rx || tx_valid !== 1'b0) begin
         bad++; $display("FAIL simultaneous_after got=%b/%h/%b exp=0/1234/0", rx_valid, rx_data, tx_valid);
      end
   endtask

   task automatic test_rx_random();
      logic r;
      logic [DW-1:0] b;
      step();
      for (int i = 0; i < 30; i++) begin
         r = 1'($urandom_range(0, 1));
         b = $urandom;
         ctrl_rx = r; bus_in = b; ctrl_bp = 1'($urandom_range(0, 1));
         step();
         if (r) exp_rx = b;
         total++;
         if (rx_valid !== r || rx_data !== exp_rx || request !== '0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL rx_random cyc%0d got=%b/%h/%b/%b exp=%b/%h/0/0",
                     i, rx_valid, rx_data, request, tx_valid, r, exp_rx);
         end
      end
      ctrl_rx = 1'b0; ctrl_bp = 1'b0;
   endtask

   task automatic test_saturation_wrap();
      push_pkt(other_dest(), $urandom);
      drain_one(model_q.pop_front(), 300);
      total++;
      if (max_wait !== 8'd255) begin bad++; $display("FAIL saturate got=%0d exp=255", max_wait); end
      for (int i = 0; i < 9; i++) begin
         push_pkt(other_dest(), $urandom);
         drain_one(model_q.pop_front(), $urandom_range(0, 3));
      end
      total++;
      if (max_wait !== 8'd255) begin bad++; $display("FAIL saturate_hold got=%0d exp=255", max_wait); end
   endtask

   task automatic test_random_traffic();
      int burst;
      for (int r = 0; r < 8; r++) begin
         burst = $urandom_range(1, 6);
         for (int i = 0; i < burst; i++) push_pkt(DSW'($urandom_range(0, 7)), $urandom);
         while (model_q.size() > 0) drain_one(model_q.pop_front(), $urandom_range(0, 5));
      end
   endtask

   task automatic test_reset_mid_send();
      int n;
      push_pkt(other_dest(), $urandom);
      push_pkt(other_dest(), $urandom);
      push_pkt(other_dest(), $urandom);
      n = 0;
      while (!request[DSW] && n < 20) begin step(); n++; end
      ctrl_tx = 1'b1;
      step();
      ctrl_tx = 1'b0;
      total++;
      if (tx_valid !== 1'b1) begin bad++; $display("FAIL mid_send_tx got=%b exp=1", tx_valid); end
      reset = 1'b1;
      step();
      check_reset_values("reset_mid_send");
      reset = 1'b0;
      model_q.delete();
      exp_rx = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         total++;
         if (request !== '0 || tx_valid !== 1'b0 || enq_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset got=%b/%b/%b exp=0/0/1", request, tx_valid, enq_ready);
         end
      end
      drop_used = drop_seen;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_self_addr();
      test_spurious();
      test_rx_random();
      test_saturation_wrap();
      test_random_traffic();
      test_reset_mid_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
